// File: rtl/mem_init_pkg.sv
// Shared types for the memory-init sink: controller states and
// the default fill pattern.
package mem_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CHECK,
        ST_READY,
        ST_FAIL
    } state_e;

    localparam logic [31:0] INIT_VALUE_DEF = 32'h0000_0000;

endpackage

// File: rtl/mem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port,
// read-first on same-address collisions.
module mem_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_init_sink.sv
// Consumes the init-sequencer stream, fills and verifies the RAM,
// then hands the RAM over to the user read/write port.
module mem_init_sink
    import mem_init_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(INIT_VALUE_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_valid,
    input  logic [31:0]       init_addr,
    input  logic              init_done,
    input  logic              inj_err,
    input  logic              user_wr_en,
    input  logic [ADDR_W-1:0] user_wr_addr,
    input  logic [DATA_W-1:0] user_wr_data,
    input  logic              user_rd_en,
    input  logic [ADDR_W-1:0] user_rd_addr,
    output logic [DATA_W-1:0] user_rd_data,
    output logic              user_rd_valid,
    output logic              mem_ready,
    output logic              check_err,
    output logic [ADDR_W:0]   err_count
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] LSB_C = DATA_W'(1);

    state_e          state_q, state_d;
    logic            done_q;
    logic [ADDR_W:0] chk_cnt_q, chk_cnt_d;
    logic            cmp_pend_q, cmp_pend_d;
    logic [ADDR_W:0] err_cnt_q, err_cnt_d;
    logic            check_err_q, check_err_d;
    logic            rd_valid_q, rd_valid_d;

    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    logic            init_hit;
    logic            done_rise;
    logic            mismatch;
    logic [ADDR_W:0] err_inc;

    assign init_hit  = init_valid && (init_addr < 32'(DEPTH));
    assign done_rise = init_done && !done_q;
    assign mismatch  = cmp_pend_q && (ram_rd_data != INIT_VALUE);
    assign err_inc   = (err_cnt_q == DEPTH_C) ? err_cnt_q
                                              : err_cnt_q + ONE_C;

    always_comb begin
        state_d     = state_q;
        chk_cnt_d   = chk_cnt_q;
        cmp_pend_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        check_err_d = check_err_q;
        rd_valid_d  = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = user_wr_addr;
        ram_wr_data = user_wr_data;
        ram_rd_en   = 1'b0;
        ram_rd_addr = user_rd_addr;

        // Init writes land in every state; they also force INIT.
        if (init_hit) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = init_addr[ADDR_W-1:0];
            ram_wr_data = inj_err ? (INIT_VALUE ^ LSB_C) : INIT_VALUE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (init_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (done_rise) begin
                    state_d     = ST_CHECK;
                    chk_cnt_d   = '0;
                    err_cnt_d   = '0;
                    check_err_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (init_valid) begin
                    state_d = ST_INIT;
                end else begin
                    ram_rd_en   = chk_cnt_q < DEPTH_C;
                    ram_rd_addr = chk_cnt_q[ADDR_W-1:0];
                    cmp_pend_d  = ram_rd_en;
                    chk_cnt_d   = chk_cnt_q + ONE_C;
                    if (mismatch) err_cnt_d = err_inc;
                    if (chk_cnt_q == DEPTH_C) begin
                        check_err_d = (err_cnt_d != '0);
                        state_d     = (err_cnt_d == '0) ? ST_READY
                                                        : ST_FAIL;
                    end
                end
            end
            ST_READY: begin
                ram_rd_en  = user_rd_en;
                rd_valid_d = user_rd_en;
                if (init_valid) begin
                    state_d = ST_INIT;
                end else if (user_wr_en) begin
                    ram_wr_en = 1'b1;
                end
            end
            ST_FAIL: begin
                if (init_valid) state_d = ST_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            chk_cnt_q   <= '0;
            cmp_pend_q  <= 1'b0;
            err_cnt_q   <= '0;
            check_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= init_done;
            chk_cnt_q   <= chk_cnt_d;
            cmp_pend_q  <= cmp_pend_d;
            err_cnt_q   <= err_cnt_d;
            check_err_q <= check_err_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    mem_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Read data is zeroed when not qualified so reset and idle are clean.
    assign user_rd_data  = rd_valid_q ? ram_rd_data : '0;
    assign user_rd_valid = rd_valid_q;
    assign mem_ready     = (state_q == ST_READY);
    assign check_err     = check_err_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_mem_init_sink.sv
// Self-checking bench for mem_init_sink: a phase-level model plus
// directed init/user scenarios with literal expectations.
module tb_mem_init_sink;

    localparam int          DEPTH = 32;
    localparam logic [31:0] IV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_valid = 1'b0;
    logic [31:0] init_addr = '0;
    logic        init_done = 1'b0;
    logic        inj_err = 1'b0;
    logic        user_wr_en = 1'b0;
    logic [4:0]  user_wr_addr = '0;
    logic [31:0] user_wr_data = '0;
    logic        user_rd_en = 1'b0;
    logic [4:0]  user_rd_addr = '0;
    logic [31:0] user_rd_data;
    logic        user_rd_valid;
    logic        mem_ready;
    logic        check_err;
    logic [5:0]  err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_init_sink dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_valid    (init_valid),
        .init_addr     (init_addr),
        .init_done     (init_done),
        .inj_err       (inj_err),
        .user_wr_en    (user_wr_en),
        .user_wr_addr  (user_wr_addr),
        .user_wr_data  (user_wr_data),
        .user_rd_en    (user_rd_en),
        .user_rd_addr  (user_rd_addr),
        .user_rd_data  (user_rd_data),
        .user_rd_valid (user_rd_valid),
        .mem_ready     (mem_ready),
        .check_err     (check_err),
        .err_count     (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Phase-level model: memory as an array, check outcome computed by
    // counting mismatching words compared so far.
    typedef enum {M_IDLE, M_INIT, M_CHECK, M_READY, M_FAIL} mphase_e;

    mphase_e     ph;
    logic [31:0] mmem [DEPTH];
    int          k;
    logic        done_prev;
    logic        exp_ready, exp_err, exp_rv;
    logic [5:0]  exp_cnt;
    logic [31:0] exp_rd;

    function automatic logic [5:0] mism(input int upto);
        int n = 0;
        for (int i = 0; i <= upto && i < DEPTH; i++)
            if (mmem[i] !== IV) n++;
        return 6'(n > DEPTH ? DEPTH : n);
    endfunction

    initial begin
        logic        rv;
        logic [31:0] rd;
        ph = M_IDLE; k = 0; done_prev = 1'b0;
        exp_ready = 0; exp_err = 0; exp_rv = 0; exp_cnt = 0; exp_rd = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = M_IDLE; k = 0; done_prev = 1'b0;
                exp_ready = 0; exp_err = 0; exp_rv = 0;
                exp_cnt = 0; exp_rd = 0;
            end else begin
                rv = 1'b0;
                rd = '0;
                if (ph == M_READY && user_rd_en) begin
                    rv = 1'b1;
                    rd = mmem[user_rd_addr];
                end
                if (ph == M_READY && user_wr_en && !init_valid)
                    mmem[user_wr_addr] = user_wr_data;
                if (init_valid && init_addr < DEPTH)
                    mmem[init_addr[4:0]] = inj_err ? (IV ^ 32'h1) : IV;
                if (ph == M_INIT && init_done && !done_prev) begin
                    ph = M_CHECK; k = 0; exp_cnt = 0; exp_err = 0;
                end else if (init_valid) begin
                    ph = M_INIT;
                end else if (ph == M_CHECK) begin
                    k++;
                    exp_cnt = mism(k - 2);
                    if (k == DEPTH + 1) begin
                        exp_err = (exp_cnt != 0);
                        ph = (exp_cnt == 0) ? M_READY : M_FAIL;
                    end
                end
                done_prev = init_done;
                exp_ready = (ph == M_READY);
                exp_rv = rv;
                exp_rd = rd;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
            chk("check_err", 32'(check_err), 32'(exp_err));
            chk("err_count", 32'(err_count), 32'(exp_cnt));
            chk("rd_valid", 32'(user_rd_valid), 32'(exp_rv));
            if (exp_rv) chk("rd_data", user_rd_data, exp_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int i1, input int i2, input bit uw);
        for (int a = 0; a <= DEPTH; a++) begin
            init_valid   = 1'b1;
            init_addr    = 32'(a);
            inj_err      = (a == i1) || (a == i2);
            user_wr_en   = uw && a >= 20 && a <= 22;
            user_wr_addr = 5'd5;
            user_wr_data = 32'hFFFF_FFFF;
            user_rd_en   = uw && a >= 20 && a <= 22;
            user_rd_addr = 5'd5;
            step();
            if (a == 0) chk("ready_after_init", 32'(mem_ready), 0);
        end
        init_valid = 1'b0;
        inj_err    = 1'b0;
        user_wr_en = 1'b0;
        user_rd_en = 1'b0;
        init_addr  = '0;
        step();
        init_done = 1'b1;
    endtask

    task automatic finish_chk(input bit pass, input int cnt);
        repeat (DEPTH + 1) step();
        chk("check_len_ready", 32'(mem_ready), 0);
        chk("check_len_err", 32'(check_err), 0);
        step();
        chk("end_ready", 32'(mem_ready), 32'(pass));
        chk("end_check_err", 32'(check_err), 32'(!pass));
        chk("end_err_count", 32'(err_count), 32'(cnt));
        init_done = 1'b0;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_valid", 32'(user_rd_valid), 0);
        chk("rst_data", user_rd_data, 0);

        // Full upstream init, clean check.
        beats(-1, -1, 1'b0);
        finish_chk(1'b1, 0);

        // User write then read back.
        user_wr_en = 1'b1; user_wr_addr = 5'd5; user_wr_data = 32'hDEAD_BEEF;
        step();
        user_wr_en = 1'b0; user_rd_en = 1'b1; user_rd_addr = 5'd5;
        step();
        user_rd_en = 1'b0;
        chk("rd5_valid", 32'(user_rd_valid), 1);
        chk("rd5_data", user_rd_data, 32'hDEAD_BEEF);
        step();
        chk("rd5_valid_drop", 32'(user_rd_valid), 0);

        // Same-cycle write and read returns old data.
        user_wr_en = 1'b1; user_wr_addr = 5'd7; user_wr_data = 32'h1234;
        user_rd_en = 1'b1; user_rd_addr = 5'd7;
        step();
        user_wr_en = 1'b0; user_rd_en = 1'b0;
        chk("rf_old_data", user_rd_data, IV);
        user_rd_en = 1'b1;
        step();
        user_rd_en = 1'b0;
        chk("rf_new_data", user_rd_data, 32'h1234);

        // Re-init from READY with user traffic during INIT.
        chk("pre_reinit_ready", 32'(mem_ready), 1);
        beats(-1, -1, 1'b1);
        finish_chk(1'b1, 0);
        user_rd_en = 1'b1; user_rd_addr = 5'd5;
        step();
        user_rd_en = 1'b0;
        chk("reinit_wiped", user_rd_data, IV);

        // Injected errors at 3 and 9.
        beats(3, 9, 1'b0);
        finish_chk(1'b0, 2);
        chk("model_cnt", 32'(exp_cnt), 2);
        user_rd_en = 1'b1; user_rd_addr = 5'd3;
        step();
        user_rd_en = 1'b0;
        chk("fail_no_valid", 32'(user_rd_valid), 0);

        // Reset in the middle of a failing check.
        beats(0, 1, 1'b0);
        repeat (10) step();
        chk("mid_check_cnt", 32'(err_count), 2);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(mem_ready), 0);
        chk("arst_err", 32'(check_err), 0);
        chk("arst_cnt", 32'(err_count), 0);
        chk("arst_valid", 32'(user_rd_valid), 0);
        chk("arst_data", user_rd_data, 0);
        init_done = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        beats(-1, -1, 1'b0);
        finish_chk(1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
